th_disp_sel: RTL and testbench

TH_DISP_SEL -- requirements
Module: th_disp_sel

---
 rtl/th_disp_sel.sv | 169 ++++++++++++++++
 tb/tb_th_disp_sel.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/th_disp_sel.sv
// DHT11 temperature/humidity display selector: shadows sensor bytes, pages between
// temperature and humidity, blanks on stale/no data. Optional alarm blink: TH_ALARM_EN.
module th_disp_sel #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int PAGE_MS     = 3000,
    parameter int STALE_MS    = 5000,
    parameter int MODE        = 0,
    parameter int TEMP_HI_X10 = 350
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  temp_int,
    input  logic [7:0]  temp_deci,
    input  logic [7:0]  humi_int,
    input  logic [7:0]  humi_deci,
    input  logic        dht11_valid,
    input  logic        key_flag,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        seg_en,
    output logic        sign,
    output logic        page,
    output logic        stale,
    output logic        alarm
);
    localparam int MS_DIV = CLK_FREQ / 1000;
    localparam int MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int PG_W   = $clog2(PAGE_MS + 1);
    localparam int ST_W   = $clog2(STALE_MS + 1);

    logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [PG_W-1:0] pg_tmr_q, pg_tmr_d;
    logic [ST_W-1:0] st_tmr_q, st_tmr_d;
    logic [7:0]      t_int_q, t_int_d, t_deci_q, t_deci_d;
    logic [7:0]      h_int_q, h_int_d, h_deci_q, h_deci_d;
    logic            page_q, page_d, stale_q, stale_d, nodata_q, nodata_d;
    logic [19:0]     data_q, data_d;
    logic [5:0]      point_q, point_d;
    logic            sign_q, sign_d, seg_en_q, seg_en_d;
    logic            ms_tick, pg_timeout, seg_on, blink_off;
    logic [7:0]      int_sel, deci_sel;
    logic [3:0]      deci_clamp;
    logic [11:0]     disp_val;

    always_comb begin
        ms_tick  = (ms_cnt_q == MS_W'(MS_DIV - 1));
        ms_cnt_d = ms_tick ? '0 : ms_cnt_q + 1'b1;

        t_int_d  = t_int_q;
        t_deci_d = t_deci_q;
        h_int_d  = h_int_q;
        h_deci_d = h_deci_q;
        if (dht11_valid) begin
            t_int_d  = temp_int;
            t_deci_d = temp_deci;
            h_int_d  = humi_int;
            h_deci_d = humi_deci;
        end

        // key and timeout in the same cycle collapse into a single toggle
        pg_timeout = (MODE == 0) && ms_tick && (pg_tmr_q == PG_W'(PAGE_MS - 1));
        page_d     = page_q ^ (key_flag | pg_timeout);
        pg_tmr_d   = pg_tmr_q;
        if ((MODE != 0) || key_flag || pg_timeout) pg_tmr_d = '0;
        else if (ms_tick)                          pg_tmr_d = pg_tmr_q + 1'b1;

        st_tmr_d = st_tmr_q;
        if (dht11_valid)                                      st_tmr_d = '0;
        else if (ms_tick && (st_tmr_q != ST_W'(STALE_MS)))    st_tmr_d = st_tmr_q + 1'b1;
        stale_d  = !dht11_valid && (st_tmr_d == ST_W'(STALE_MS));
        nodata_d = nodata_q & ~dht11_valid;

        int_sel    = page_q ? h_int_q  : t_int_q;
        deci_sel   = page_q ? h_deci_q : {1'b0, t_deci_q[6:0]};
        deci_clamp = (deci_sel > 8'd9) ? 4'd9 : deci_sel[3:0];
        disp_val   = 12'(int_sel) * 12'd10 + 12'(deci_clamp);

        seg_on   = !nodata_q && !stale_q && !blink_off;
        data_d   = {8'b0, disp_val};
        point_d  = seg_on ? 6'b000010 : 6'b000000;
        sign_d   = !page_q && t_deci_q[7];
        seg_en_d = seg_on;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ms_cnt_q <= '0;
            pg_tmr_q <= '0;
            st_tmr_q <= '0;
            t_int_q  <= '0;
            t_deci_q <= '0;
            h_int_q  <= '0;
            h_deci_q <= '0;
            page_q   <= 1'b0;
            stale_q  <= 1'b0;
            nodata_q <= 1'b1;
            data_q   <= '0;
            point_q  <= '0;
            sign_q   <= 1'b0;
            seg_en_q <= 1'b0;
        end else begin
            ms_cnt_q <= ms_cnt_d;
            pg_tmr_q <= pg_tmr_d;
            st_tmr_q <= st_tmr_d;
            t_int_q  <= t_int_d;
            t_deci_q <= t_deci_d;
            h_int_q  <= h_int_d;
            h_deci_q <= h_deci_d;
            page_q   <= page_d;
            stale_q  <= stale_d;
            nodata_q <= nodata_d;
            data_q   <= data_d;
            point_q  <= point_d;
            sign_q   <= sign_d;
            seg_en_q <= seg_en_d;
        end
    end

`ifdef TH_ALARM_EN
    logic [11:0] temp_val;
    logic [7:0]  blk_cnt_q, blk_cnt_d;
    logic        blk_off_q, blk_off_d, alarm_q, alarm_d;

    always_comb begin
        temp_val  = 12'(t_int_q) * 12'd10
                  + ((t_deci_q[6:0] > 7'd9) ? 12'd9 : 12'(t_deci_q[3:0]));
        alarm_d   = !nodata_q && !t_deci_q[7] && (temp_val >= 12'(TEMP_HI_X10));
        blk_cnt_d = blk_cnt_q;
        blk_off_d = blk_off_q;
        // blink phase restarts in the visible half whenever the alarm rises
        if (!alarm_q) begin
            blk_cnt_d = '0;
            blk_off_d = 1'b0;
        end else if (ms_tick) begin
            if (blk_cnt_q == 8'd249) begin
                blk_cnt_d = '0;
                blk_off_d = ~blk_off_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blk_cnt_q <= '0;
            blk_off_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            blk_off_q <= blk_off_d;
            alarm_q   <= alarm_d;
        end
    end

    assign blink_off = blk_off_q;
    assign alarm     = alarm_q;
`else
    assign blink_off = 1'b0;
    assign alarm     = 1'b0;
`endif

    assign data   = data_q;
    assign point  = point_q;
    assign seg_en = seg_en_q;
    assign sign   = sign_q;
    assign page   = page_q;
    assign stale  = stale_q;
endmodule

// File: tb/tb_th_disp_sel.sv
// Directed bench for th_disp_sel at CLK_FREQ=10_000 (1 ms = 10 cycles), PAGE_MS=5, STALE_MS=8.
module tb_th_disp_sel;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  temp_int = '0, temp_deci = '0, humi_int = '0, humi_deci = '0;
    logic        dht11_valid = 1'b0, key_flag = 1'b0;
    logic [19:0] data;
    logic [5:0]  point;
    logic        seg_en, sign, page, stale, alarm;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

`ifdef TH_ALARM_EN
    localparam int EXP_ALARM = 1;
    localparam int EXP_BLINK = 0;
`else
    localparam int EXP_ALARM = 0;
    localparam int EXP_BLINK = 1;
`endif

    th_disp_sel #(.CLK_FREQ(10_000), .PAGE_MS(5), .STALE_MS(8), .MODE(0), .TEMP_HI_X10(350)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .temp_int(temp_int), .temp_deci(temp_deci), .humi_int(humi_int), .humi_deci(humi_deci),
        .dht11_valid(dht11_valid), .key_flag(key_flag),
        .data(data), .point(point), .seg_en(seg_en), .sign(sign),
        .page(page), .stale(stale), .alarm(alarm)
    );

    always #5 sys_clk = ~sys_clk;

    // cyc = number of rising edges since reset release
    always @(posedge sys_clk) if (sys_rst_n) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // return at the falling edge following rising edge n
    task automatic at_neg(input int n);
        while (cyc < n) @(negedge sys_clk);
        if (cyc != n) @(negedge sys_clk);
    endtask

    task automatic pulse_valid(input int e, input logic [7:0] ti, td, hi, hd);
        at_neg(e - 1);
        temp_int = ti; temp_deci = td; humi_int = hi; humi_deci = hd;
        dht11_valid = 1'b1;
        at_neg(e);
        dht11_valid = 1'b0;
    endtask

    task automatic pulse_key(input int e);
        at_neg(e - 1);
        key_flag = 1'b1;
        at_neg(e);
        key_flag = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_data", data, 0);
        chk("rst_seg_en", seg_en, 0);
        sys_rst_n = 1'b1;
        at_neg(1);
        chk("idle_seg_en", seg_en, 0);
        chk("idle_point", point, 0);
        chk("idle_data", data, 0);
        chk("idle_alarm", alarm, 0);
        chk("idle_page", page, 0);

        pulse_valid(3, 8'd25, 8'd3, 8'd60, 8'd0);
        at_neg(4);
        chk("v1_data", data, 253);
        chk("v1_point", point, 2);
        chk("v1_seg_en", seg_en, 1);
        chk("v1_page", page, 0);
        chk("v1_sign", sign, 0);
        at_neg(49);
        chk("page_pre_tmo", page, 0);
        at_neg(51);
        chk("page_tmo", page, 1);
        chk("humi_data", data, 600);

        at_neg(79);
        chk("stale_pre", stale, 0);
        at_neg(81);
        chk("stale_set", stale, 1);
        chk("stale_seg_en", seg_en, 0);
        chk("stale_point", point, 0);

        pulse_valid(85, 8'd2, 8'h85, 8'd60, 8'd0);
        at_neg(87);
        chk("v2_stale", stale, 0);
        chk("v2_seg_en", seg_en, 1);
        chk("v2_humi_data", data, 600);
        chk("v2_humi_sign", sign, 0);
        at_neg(102);
        chk("neg_page", page, 0);
        chk("neg_data", data, 25);
        chk("neg_sign", sign, 1);

        pulse_valid(160, 8'd2, 8'h85, 8'd60, 8'd12);
        chk("race_stale", stale, 0);
        at_neg(162);
        chk("race_stale2", stale, 0);
        chk("race_seg_en", seg_en, 1);
        chk("clamp_data", data, 609);

        pulse_key(200);
        chk("key_tmo_page", page, 0);
        pulse_key(215);
        at_neg(216);
        chk("key_page", page, 1);
        at_neg(255);
        chk("key_restart", page, 1);
        at_neg(261);
        chk("key_next_tmo", page, 0);

        pulse_valid(262, 8'd36, 8'd0, 8'd60, 8'd0);
        at_neg(264);
        chk("hot_data", data, 360);
        chk("hot_alarm", alarm, EXP_ALARM);
        chk("hot_seg_en", seg_en, 1);
        for (int e = 312; e <= 2712; e += 50) pulse_valid(e, 8'd36, 8'd0, 8'd60, 8'd0);
        at_neg(2759);
        chk("blink_on", seg_en, 1);
        at_neg(2764);
        chk("blink_off", seg_en, EXP_BLINK);
        chk("blink_alarm", alarm, EXP_ALARM);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
